prog_loader_ctrl: RTL and testbench
===================================

Name: prog_loader_ctrl

Overview:
Parametrised system controller that downloads a program into instruction RAM over a valid/ready stream, then runs the CPU core until it fetches the STOP word. It adds several features to the fixed IDLE/LOAD/RUN sequencer: a load handshake, capacity and empty-program checks, a run timeout, cycle and word counters, re-run without reload, and abort. It sits at the system top between the program source, the instruction RAM write port and the core's run enable.

Parameters:
ADDR_W, 16, instruction RAM byte-address width
DATA_W, 32, instruction word width
DEPTH_WORDS, 4096, instruction RAM capacity in words; DEPTH_WORDS*BYTE_STEP <= 2**ADDR_W
BYTE_STEP, 4, byte-address increment per word
STOP_WORD, 32'h007F007F, terminator / halt instruction (DATA_W bits)
RUN_TIMEOUT, 0, maximum RUN cycles; 0 disables the timeout
CNT_W, 32, cycle_count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse: begin a new download (accepted in IDLE, DONE, ERR)
rerun  in  1  pulse: rerun the loaded program (accepted in DONE only)
abort  in  1  return to IDLE from any state
load_valid  in  1  load_data valid
load_data  in  DATA_W  program word
load_ready  out  1  controller accepts a word this cycle
ram_we  out  1  instruction RAM write strobe
ram_waddr  out  ADDR_W  write byte address
ram_wdata  out  DATA_W  write data
fetch_valid  in  1  core fetch_instr valid this cycle
fetch_instr  in  DATA_W  instruction fetched by the core
cpu_run  out  1  core run enable (high only in RUN)
loading  out  1  high in LOAD
done  out  1  sticky: program halted on STOP_WORD
err_empty  out  1  sticky: STOP_WORD was the first word
err_overflow  out  1  sticky: program exceeded DEPTH_WORDS
err_timeout  out  1  sticky: RUN_TIMEOUT reached
word_count  out  ADDR_W+1  words written in the last load, including STOP
cycle_count  out  CNT_W  RUN cycles of the last run, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, including counters and flags.
- States: IDLE, LOAD, ARM, RUN, DONE, ERR. Outputs are registered unless noted.
- Priority: abort > rerun > start. abort -> IDLE next cycle from any state. abort clears done and all err flags; counters are retained.
- IDLE/DONE/ERR, on start:
  - go to LOAD;
  - clear word_count, cycle_count, done and all err flags.
- LOAD:
  - load_ready = 1, driven combinationally from state.
  - A word is accepted when load_valid & load_ready.
  - ram_we, ram_waddr and ram_wdata are combinational in the accept cycle. ram_waddr = word_count*BYTE_STEP, truncated to ADDR_W.
  - Accepted non-STOP word with word_count < DEPTH_WORDS-1: write it; word_count += 1; stay in LOAD.
  - Accepted STOP_WORD with word_count == 0: no write; err_empty = 1; go to ERR.
  - Accepted STOP_WORD with 0 < word_count < DEPTH_WORDS: write it (the core must fetch it to halt); word_count += 1; go to ARM.
  - Accepted non-STOP word with word_count == DEPTH_WORDS-1: no write, since the last slot is reserved for STOP; err_overflow = 1; go to ERR.
  - No accept: hold state.
- ARM: one cycle with cpu_run = 0, giving the core a clean PC restart. Clear cycle_count. Go to RUN.
- RUN:
  - cpu_run = 1; cycle_count += 1 each cycle, saturating at all-ones.
  - fetch_valid & fetch_instr == STOP_WORD: done = 1; go to DONE. cycle_count still counts that cycle.
  - RUN_TIMEOUT != 0 and cycle_count == RUN_TIMEOUT-1 with no STOP this cycle: err_timeout = 1; go to ERR.
  - STOP and timeout in the same cycle: STOP wins.
  - load_data and load_valid are ignored; load_ready = 0.
- DONE:
  - done stays high.
  - rerun: clear done; go to ARM. RAM contents and word_count are unchanged.
  - start: reload as described above.
- ERR: flags stay high until start or abort. rerun is ignored.
- Unused or unknown state encoding -> IDLE.
- ram_we is never asserted outside LOAD; cpu_run is never asserted outside RUN.

Test Plan:
- Load 0x00500093, 0x00100113, STOP with load_valid held high -> ram_we on 3 consecutive cycles at addresses 0x0, 0x4, 0x8; word_count = 3; ARM for 1 cycle; cpu_run rises on the following cycle.
- In RUN, drive fetch_valid with 0x00000013 for 9 cycles, then STOP -> done = 1; cycle_count = 10; cpu_run = 0 next cycle; then rerun -> ARM, RUN again, cycle_count restarts at 0 and word_count stays 3.
- STOP as the first word -> no ram_we; err_empty = 1; state ERR; start -> flags clear and LOAD re-entered.
- DEPTH_WORDS = 4: words 1, 2, 3 are written; a 4th non-STOP word -> err_overflow = 1 and no write. Separately, 3 words + STOP -> STOP written at 0xC; word_count = 4.
- RUN_TIMEOUT = 8 with no STOP -> err_timeout after exactly 8 RUN cycles; cycle_count = 8. With STOP presented on cycle 8 -> done = 1, err_timeout = 0.
- Abort mid-LOAD after 2 words -> IDLE next cycle; load_ready = 0; word_count = 2 retained. Asserting rst_n low mid-RUN -> cpu_run drops to 0 asynchronously and all outputs read 0.

Source files
------------

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: downloads a program into instruction RAM over a
// valid/ready stream, then runs the core until it fetches STOP_WORD.
// Adds load handshake, capacity/empty checks, run timeout, word and
// cycle counters, re-run without reload, and abort.
module prog_loader_ctrl #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter int                BYTE_STEP   = 4,
  parameter logic [DATA_W-1:0] STOP_WORD   = DATA_W'(32'h007F007F),
  parameter int unsigned       RUN_TIMEOUT = 0,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rerun,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_run,
  output logic              loading,
  output logic              done,
  output logic              err_empty,
  output logic              err_overflow,
  output logic              err_timeout,
  output logic [ADDR_W:0]   word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Last RAM slot is reserved for the STOP word.
  localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTE_STEP);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(RUN_TIMEOUT - 1);
  localparam bit                TO_EN     = (RUN_TIMEOUT != 0);

  logic [2:0] state;
  logic       accept;
  logic       is_stop;
  logic       fetch_stop;
  logic       can_start;

  // Handshake, write port and status decode straight from the state register.
  always_comb begin
    load_ready = (state == S_LOAD);
    loading    = (state == S_LOAD);
    cpu_run    = (state == S_RUN);
    accept     = load_valid & load_ready;
    is_stop    = (load_data == STOP_WORD);
    ram_we     = accept & (is_stop ? (word_count != '0) : (word_count != LAST_SLOT));
    ram_waddr  = ram_we ? (word_count[ADDR_W-1:0] * STEP) : '0;
    ram_wdata  = ram_we ? load_data : '0;
    fetch_stop = fetch_valid & (fetch_instr == STOP_WORD);
    can_start  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  end

  // Sequencer: abort > rerun > start, then per-state behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      word_count   <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      err_empty    <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      done         <= 1'b0;
      err_empty    <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else if ((state == S_DONE) && rerun) begin
      state <= S_ARM;
      done  <= 1'b0;
    end else if (can_start) begin
      state        <= S_LOAD;
      word_count   <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      err_empty    <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: state <= state;
        S_LOAD: begin
          if (accept) begin
            if (is_stop) begin
              if (word_count == '0) begin
                err_empty <= 1'b1;
                state     <= S_ERR;
              end else begin
                word_count <= word_count + 1'b1;
                state      <= S_ARM;
              end
            end else if (word_count == LAST_SLOT) begin
              err_overflow <= 1'b1;
              state        <= S_ERR;
            end else begin
              word_count <= word_count + 1'b1;
            end
          end
        end
        S_ARM: begin
          cycle_count <= '0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (fetch_stop) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (TO_EN && (cycle_count == TO_LAST)) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: two instances (small RAM / no timeout, and
// default RAM / 8-cycle timeout) share one directed stimulus stream and are
// compared every cycle against a phase-level model, plus literal checks.
module tb_prog_loader_ctrl;

  localparam logic [31:0] STOP = 32'h007F007F;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, rerun = 1'b0, abort = 1'b0;
  logic        load_valid = 1'b0, fetch_valid = 1'b0;
  logic [31:0] load_data = '0, fetch_instr = '0;

  logic        lr[2], we[2], run[2], ld[2], dn[2], ee[2], eo[2], et[2];
  logic [15:0] wa[2];
  logic [31:0] wd[2];
  logic [16:0] wc[2];
  logic [31:0] cc[2];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  prog_loader_ctrl #(.DEPTH_WORDS(4), .RUN_TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rerun(rerun), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[0]),
    .ram_we(we[0]), .ram_waddr(wa[0]), .ram_wdata(wd[0]),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_run(run[0]),
    .loading(ld[0]), .done(dn[0]), .err_empty(ee[0]), .err_overflow(eo[0]),
    .err_timeout(et[0]), .word_count(wc[0]), .cycle_count(cc[0]));

  prog_loader_ctrl #(.DEPTH_WORDS(4096), .RUN_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rerun(rerun), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr[1]),
    .ram_we(we[1]), .ram_waddr(wa[1]), .ram_wdata(wd[1]),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_run(run[1]),
    .loading(ld[1]), .done(dn[1]), .err_empty(ee[1]), .err_overflow(eo[1]),
    .err_timeout(et[1]), .word_count(wc[1]), .cycle_count(cc[1]));

  // Behavioural model: phase, words loaded, cycles run, sticky flags.
  typedef enum int {P_IDLE, P_LOAD, P_ARM, P_RUN, P_DONE, P_ERR} phase_t;
  int     dep[2] = '{4, 4096};
  int     tmo[2] = '{0, 8};
  phase_t mp[2]  = '{P_IDLE, P_IDLE};
  int     mwc[2] = '{0, 0};
  longint mcc[2] = '{0, 0};
  bit     md[2]  = '{0, 0};
  bit     mee[2] = '{0, 0};
  bit     meo[2] = '{0, 0};
  bit     met[2] = '{0, 0};

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_write(int i);
    if (mp[i] != P_LOAD || !load_valid) return 1'b0;
    if (load_data == STOP) return mwc[i] > 0;
    return mwc[i] < dep[i] - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mp[i] = P_IDLE; mwc[i] = 0; mcc[i] = 0;
        md[i] = 0; mee[i] = 0; meo[i] = 0; met[i] = 0;
      end else if (abort) begin
        mp[i] = P_IDLE; md[i] = 0; mee[i] = 0; meo[i] = 0; met[i] = 0;
      end else if (mp[i] == P_DONE && rerun) begin
        mp[i] = P_ARM; md[i] = 0;
      end else if (start && (mp[i] == P_IDLE || mp[i] == P_DONE || mp[i] == P_ERR)) begin
        mp[i] = P_LOAD; mwc[i] = 0; mcc[i] = 0;
        md[i] = 0; mee[i] = 0; meo[i] = 0; met[i] = 0;
      end else begin
        case (mp[i])
          P_LOAD: if (load_valid) begin
            if (load_data == STOP) begin
              if (mwc[i] == 0) begin mee[i] = 1; mp[i] = P_ERR; end
              else begin mwc[i]++; mp[i] = P_ARM; end
            end else if (mwc[i] == dep[i] - 1) begin
              meo[i] = 1; mp[i] = P_ERR;
            end else mwc[i]++;
          end
          P_ARM: begin mcc[i] = 0; mp[i] = P_RUN; end
          P_RUN: begin
            if (mcc[i] < 64'hFFFF_FFFF) mcc[i]++;
            if (fetch_valid && fetch_instr == STOP) begin md[i] = 1; mp[i] = P_DONE; end
            else if (tmo[i] != 0 && mcc[i] == tmo[i]) begin met[i] = 1; mp[i] = P_ERR; end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        bit w;
        w = m_write(i);
        chk($sformatf("load_ready[%0d]", i), 64'(lr[i]), 64'(mp[i] == P_LOAD));
        chk($sformatf("loading[%0d]", i), 64'(ld[i]), 64'(mp[i] == P_LOAD));
        chk($sformatf("cpu_run[%0d]", i), 64'(run[i]), 64'(mp[i] == P_RUN));
        chk($sformatf("ram_we[%0d]", i), 64'(we[i]), 64'(w));
        chk($sformatf("ram_waddr[%0d]", i), 64'(wa[i]), w ? 64'((mwc[i] * 4) % 65536) : 64'd0);
        chk($sformatf("ram_wdata[%0d]", i), 64'(wd[i]), w ? 64'(load_data) : 64'd0);
        chk($sformatf("word_count[%0d]", i), 64'(wc[i]), 64'(mwc[i]));
        chk($sformatf("cycle_count[%0d]", i), 64'(cc[i]), 64'(mcc[i]));
        chk($sformatf("done[%0d]", i), 64'(dn[i]), 64'(md[i]));
        chk($sformatf("err_empty[%0d]", i), 64'(ee[i]), 64'(mee[i]));
        chk($sformatf("err_overflow[%0d]", i), 64'(eo[i]), 64'(meo[i]));
        chk($sformatf("err_timeout[%0d]", i), 64'(et[i]), 64'(met[i]));
      end
      if (we[0]) wq.push_back(wa[0]);
    end
  end

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(logic [31:0] w);
    load_valid = 1'b1; load_data = w; tick(); load_valid = 1'b0; load_data = '0;
  endtask

  initial begin
    int base;
    #2 rst_n = 1'b0;
    #1 checking = 1'b1;
    tick(2);
    chk("reset cpu_run", 64'(run[0]), 64'd0);
    chk("reset word_count", 64'(wc[0]), 64'd0);
    chk("reset cycle_count", 64'(cc[0]), 64'd0);
    chk("reset flags", 64'({dn[0], ee[0], eo[0], et[0], ld[0], lr[0]}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Three-word program loaded back to back.
    pulse_start();
    load_valid = 1'b1;
    load_data = 32'h00500093; tick();
    load_data = 32'h00100113; tick();
    load_data = STOP;         tick();
    load_valid = 1'b0;
    chk("load writes", 64'(wq.size()), 64'd3);
    chk("load addr0", 64'(wq[0]), 64'h0);
    chk("load addr1", 64'(wq[1]), 64'h4);
    chk("load addr2", 64'(wq[2]), 64'h8);
    chk("load word_count", 64'(wc[0]), 64'd3);
    chk("arm cpu_run", 64'(run[0]), 64'd0);
    tick();
    chk("run cpu_run", 64'(run[0]), 64'd1);

    // Nine NOPs then STOP.
    fetch_valid = 1'b1; fetch_instr = NOP;
    tick(9);
    fetch_instr = STOP; tick();
    fetch_valid = 1'b0; fetch_instr = '0;
    chk("halt done", 64'(dn[0]), 64'd1);
    chk("halt cycle_count", 64'(cc[0]), 64'd10);
    chk("halt cpu_run", 64'(run[0]), 64'd0);

    // Rerun without reload.
    rerun = 1'b1; tick(); rerun = 1'b0;
    chk("rerun arm cpu_run", 64'(run[0]), 64'd0);
    chk("rerun done cleared", 64'(dn[0]), 64'd0);
    tick();
    chk("rerun cpu_run", 64'(run[0]), 64'd1);
    chk("rerun cycle_count", 64'(cc[0]), 64'd0);
    chk("rerun word_count", 64'(wc[0]), 64'd3);
    fetch_valid = 1'b1; fetch_instr = STOP; tick();
    fetch_valid = 1'b0; fetch_instr = '0;
    chk("rerun halt cycle_count", 64'(cc[0]), 64'd1);

    // Empty program.
    base = wq.size();
    pulse_start();
    send(STOP);
    chk("empty no write", 64'(wq.size()), 64'(base));
    chk("empty err_empty", 64'(ee[0]), 64'd1);
    rerun = 1'b1; tick(); rerun = 1'b0;
    chk("empty rerun ignored", 64'(ee[0]), 64'd1);
    pulse_start();
    chk("restart flags clear", 64'(ee[0]), 64'd0);
    chk("restart loading", 64'(ld[0]), 64'd1);

    // Overflow on the small instance.
    base = wq.size();
    load_valid = 1'b1;
    load_data = 32'd1; tick();
    load_data = 32'd2; tick();
    load_data = 32'd3; tick();
    load_data = 32'd4; tick();
    load_valid = 1'b0;
    chk("overflow writes", 64'(wq.size() - base), 64'd3);
    chk("overflow flag", 64'(eo[0]), 64'd1);
    chk("overflow word_count", 64'(wc[0]), 64'd3);

    // Full program: STOP lands in the last slot.
    pulse_start();
    load_valid = 1'b1;
    load_data = 32'd1; tick();
    load_data = 32'd2; tick();
    load_data = 32'd3; tick();
    load_data = STOP;  tick();
    load_valid = 1'b0;
    chk("full stop addr", 64'(wq[$]), 64'hC);
    chk("full word_count", 64'(wc[0]), 64'd4);
    tick(2);
    abort = 1'b1; tick(); abort = 1'b0;

    // Timeout on the second instance.
    pulse_start();
    send(32'h11); send(STOP);
    tick();
    tick(7);
    chk("timeout not yet", 64'(et[1]), 64'd0);
    tick();
    chk("timeout flag", 64'(et[1]), 64'd1);
    chk("timeout cycle_count", 64'(cc[1]), 64'd8);
    chk("timeout cpu_run", 64'(run[1]), 64'd0);
    abort = 1'b1; tick(); abort = 1'b0;

    // STOP on the timeout cycle wins.
    pulse_start();
    send(32'h11); send(STOP);
    tick();
    tick(7);
    fetch_valid = 1'b1; fetch_instr = STOP; tick();
    fetch_valid = 1'b0; fetch_instr = '0;
    chk("stop wins done", 64'(dn[1]), 64'd1);
    chk("stop wins no timeout", 64'(et[1]), 64'd0);
    chk("stop wins cycle_count", 64'(cc[1]), 64'd8);

    // Abort mid-load.
    pulse_start();
    send(32'h21); send(32'h22);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort load_ready", 64'(lr[0]), 64'd0);
    chk("abort loading", 64'(ld[0]), 64'd0);
    chk("abort word_count", 64'(wc[0]), 64'd2);

    // Asynchronous reset while running.
    pulse_start();
    send(32'h31); send(STOP);
    tick(3);
    chk("pre-reset cpu_run", 64'(run[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async cpu_run", 64'(run[0]), 64'd0);
    chk("async counters", 64'({wc[0], cc[0]}), 64'd0);
    chk("async flags", 64'({dn[0], ee[0], eo[0], et[0], ld[0], lr[0], we[0]}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
